// File: rtl/adt7320_temp_monitor.sv
// ADT7320 sample monitor: rejects 0xFFFF reads, averages 2**AVG_LOG2 samples, tracks min/max, alarm w/ hysteresis, stale.
// Latency: avg/alarm 1 clk after Nth sample, min/max 1 clk after sample; no backpressure, every in_valid is consumed.
module adt7320_temp_monitor #(
  parameter int          AVG_LOG2       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_temp,
  input  logic        in_valid,
  input  logic [15:0] thresh_hi,
  input  logic [15:0] thresh_lo,
  input  logic        clear_minmax,
  output logic [15:0] avg_temp,
  output logic        avg_valid,
  output logic [15:0] min_temp,
  output logic [15:0] max_temp,
  output logic        alarm,
  output logic        stale,
  output logic [7:0]  err_count
);

  localparam int          AW     = 16 + AVG_LOG2;
  localparam logic [31:0] TMR_TO = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_NORMAL = 2'd1,
    S_ALARM  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [AW-1:0]  r_acc;
  logic [AVG_LOG2-1:0]   r_cnt;
  logic [31:0]           r_tmr;

  logic                  w_accept;
  logic                  w_reject;
  logic                  w_block_done;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_shift;
  logic [15:0]           w_avg_new;

  assign w_accept     = in_valid && (in_temp != 16'hFFFF);
  assign w_reject     = in_valid && (in_temp == 16'hFFFF);
  assign w_block_done = w_accept && (&r_cnt);
  assign w_sum        = r_acc + AW'($signed(in_temp));
  assign w_shift      = w_sum >>> AVG_LOG2;
  assign w_avg_new    = w_shift[15:0];

  // Hysteresis decision uses the average being produced this clk, not the stale register.
  always_comb begin
    w_state_nxt = r_state;
    if (w_block_done) begin
      case (r_state)
        S_FILL, S_NORMAL:
          w_state_nxt = ($signed(w_avg_new) > $signed(thresh_hi)) ? S_ALARM : S_NORMAL;
        S_ALARM:
          w_state_nxt = ($signed(w_avg_new) < $signed(thresh_lo)) ? S_NORMAL : S_ALARM;
        default:
          w_state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  assign alarm = (r_state == S_ALARM);
  assign stale = (r_tmr == TMR_TO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      avg_temp  <= 16'h0000;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (w_block_done) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        avg_temp  <= w_avg_new;
        avg_valid <= 1'b1;
      end else if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_temp <= 16'h7FFF;
      max_temp <= 16'h8000;
    end else if (clear_minmax) begin
      min_temp <= w_accept ? in_temp : 16'h7FFF;
      max_temp <= w_accept ? in_temp : 16'h8000;
    end else if (w_accept) begin
      if ($signed(in_temp) < $signed(min_temp)) min_temp <= in_temp;
      if ($signed(in_temp) > $signed(max_temp)) max_temp <= in_temp;
    end
  end

  // Timer holds at the timeout value so stale stays asserted until the next good sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr     <= '0;
      err_count <= 8'd0;
    end else begin
      if (w_accept)             r_tmr <= '0;
      else if (r_tmr != TMR_TO) r_tmr <= r_tmr + 32'd1;
      if (w_reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_adt7320_temp_monitor.sv
// Directed bench for adt7320_temp_monitor with AVG_LOG2=2, TIMEOUT_CYCLES=1000.
module tb_adt7320_temp_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_temp;
  logic        in_valid;
  logic [15:0] thresh_hi;
  logic [15:0] thresh_lo;
  logic        clear_minmax;
  logic [15:0] avg_temp;
  logic        avg_valid;
  logic [15:0] min_temp;
  logic [15:0] max_temp;
  logic        alarm;
  logic        stale;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adt7320_temp_monitor #(.AVG_LOG2(2), .TIMEOUT_CYCLES(1000)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_temp      (in_temp),
    .in_valid     (in_valid),
    .thresh_hi    (thresh_hi),
    .thresh_lo    (thresh_lo),
    .clear_minmax (clear_minmax),
    .avg_temp     (avg_temp),
    .avg_valid    (avg_valid),
    .min_temp     (min_temp),
    .max_temp     (max_temp),
    .alarm        (alarm),
    .stale        (stale),
    .err_count    (err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] t);
    in_temp  = t;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_temp  = 16'h7000;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_avg"},   32'(avg_temp),  32'h0000);
    check({tag, "_avgv"},  32'(avg_valid), 32'h0);
    check({tag, "_min"},   32'(min_temp),  32'h7FFF);
    check({tag, "_max"},   32'(max_temp),  32'h8000);
    check({tag, "_alarm"}, 32'(alarm),     32'h0);
    check({tag, "_err"},   32'(err_count), 32'h0);
  endtask

  initial begin
    reset        = 1'b0;
    in_temp      = 16'h0000;
    in_valid     = 1'b0;
    clear_minmax = 1'b0;
    thresh_hi    = 16'h2800;
    thresh_lo    = 16'h2600;

    do_reset();
    check_reset_state("rst");
    check("rst_stale", 32'(stale), 32'h0);

    // 25,25,26,26 degC back-to-back
    send(16'h0C80); send(16'h0C80); send(16'h0D00);
    check("t1_no_early_avgv", 32'(avg_valid), 32'h0);
    send(16'h0D00);
    check("t1_avgv", 32'(avg_valid), 32'h1);
    check("t1_avg",  32'(avg_temp),  32'h0CC0);
    check("t1_min",  32'(min_temp),  32'h0C80);
    check("t1_max",  32'(max_temp),  32'h0D00);
    check("t1_alarm", 32'(alarm),    32'h0);
    idle(1);
    check("t1_avgv_pulse", 32'(avg_valid), 32'h0);

    // sum -9 -> floor(-2.25) = -3
    send(16'hFFFE); send(16'hFFFE); send(16'hFFFE); send(16'hFFFD);
    check("t2_avg", 32'(avg_temp), 32'hFFFD);
    check("t2_min", 32'(min_temp), 32'hFFFD);
    check("t2_max", 32'(max_temp), 32'h0D00);

    repeat (4) send(16'h2900);
    check("t3_avg_hi",   32'(avg_temp), 32'h2900);
    check("t3_alarm_on", 32'(alarm),    32'h1);
    repeat (4) send(16'h2700);
    check("t3_avg_mid",    32'(avg_temp), 32'h2700);
    check("t3_alarm_hold", 32'(alarm),    32'h1);
    repeat (4) send(16'h2500);
    check("t3_avg_lo",    32'(avg_temp), 32'h2500);
    check("t3_alarm_off", 32'(alarm),    32'h0);

    clear_minmax = 1'b1;
    idle(1);
    clear_minmax = 1'b0;
    check("t4_clr_min", 32'(min_temp), 32'h7FFF);
    check("t4_clr_max", 32'(max_temp), 32'h8000);
    send(16'h0100); send(16'hFFFF); send(16'h0200); send(16'hFFFF);
    send(16'h0300); send(16'hFFFF);
    check("t4_no_avgv", 32'(avg_valid), 32'h0);
    send(16'h0400);
    check("t4_avgv", 32'(avg_valid), 32'h1);
    check("t4_avg",  32'(avg_temp),  32'h0280);
    check("t4_err3", 32'(err_count), 32'd3);
    check("t4_min",  32'(min_temp),  32'h0100);
    check("t4_max",  32'(max_temp),  32'h0400);
    clear_minmax = 1'b1;
    send(16'h0050);
    clear_minmax = 1'b0;
    check("t4_clrs_min", 32'(min_temp), 32'h0050);
    check("t4_clrs_max", 32'(max_temp), 32'h0050);
    for (int i = 0; i < 300; i++) send(16'hFFFF);
    check("t4_err_sat", 32'(err_count), 32'd255);
    check("t4_min_keep", 32'(min_temp), 32'h0050);

    // A reject mid-wait must not restart the timer
    send(16'h0060);
    idle(500);
    send(16'hFFFF);
    idle(498);
    check("t5_not_stale", 32'(stale), 32'h0);
    idle(1);
    check("t5_stale", 32'(stale), 32'h1);
    idle(5);
    check("t5_stale_hold", 32'(stale), 32'h1);
    send(16'h0070);
    check("t5_unstale", 32'(stale), 32'h0);

    // three samples of the current block are pending here
    do_reset();
    check_reset_state("t6_rst");
    send(16'h0100); send(16'h0100); send(16'h0100);
    check("t6_no_avgv", 32'(avg_valid), 32'h0);
    send(16'h0100);
    check("t6_avgv", 32'(avg_valid), 32'h1);
    check("t6_avg",  32'(avg_temp),  32'h0100);
    check("t6_min",  32'(min_temp),  32'h0100);
    check("t6_max",  32'(max_temp),  32'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
